neuron_core_bus_master: RTL and testbench

NEURON_CORE_BUS_MASTER -- requirements
Module: neuron_core_bus_master

---
 rtl/neuron_core_bus_master_pkg.sv | 34 +++
 rtl/neuron_core_addr_encoder.sv | 21 ++
 rtl/neuron_core_bus_master.sv | 187 ++++++++++++++++++
 tb/tb_neuron_core_bus_master.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_core_bus_master_pkg.sv
// Shared definitions for the neuron core Wishbone bus master: region codes,
// region sizes, FSM state encoding and the per-region index wrap helper.
package neuron_core_bus_master_pkg;

    localparam logic [1:0] REGION_SYNAPSE = 2'b00;
    localparam logic [1:0] REGION_PARAM   = 2'b01;
    localparam logic [1:0] REGION_SPIKE   = 2'b10;
    localparam logic [1:0] REGION_ILLEGAL = 2'b11;

    localparam int SYNAPSE_WORDS = 2048;
    localparam int PARAM_WORDS   = 256;
    localparam int SPIKE_WORDS   = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_BUS    = 3'd2,
        ST_RDOUT  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Next word index, wrapping inside the region's word count.
    function automatic logic [10:0] next_index(input logic [1:0] region,
                                               input logic [10:0] index);
        logic [10:0] inc;
        inc = index + 11'd1;
        case (region)
            REGION_PARAM: return inc & 11'(PARAM_WORDS - 1);
            REGION_SPIKE: return inc & 11'(SPIKE_WORDS - 1);
            default:      return inc & 11'(SYNAPSE_WORDS - 1);
        endcase
    endfunction

endpackage

// File: rtl/neuron_core_addr_encoder.sv
// Maps a region code and word index onto the 15-bit byte offset inside
// the neuron core window.
module neuron_core_addr_encoder
    import neuron_core_bus_master_pkg::*;
(
    input  logic [1:0]  region,
    input  logic [10:0] index,
    output logic [14:0] offset
);

    always_comb begin
        offset = '0;
        case (region)
            REGION_SYNAPSE: offset = {2'b00, index, 2'b00};
            REGION_PARAM:   offset = {2'b01, 1'b0, index[7:0], 4'h0};
            REGION_SPIKE:   offset = {2'b10, 8'h00, index[2:0], 2'b00};
            default:        offset = '0;
        endcase
    end

endmodule

// File: rtl/neuron_core_bus_master.sv
// Burst engine turning region/index/length commands into single-beat
// Wishbone classic cycles against the neuron core.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// FETCH  | waiting for the next write word on the wdata stream
// BUS    | cyc/stb active, waiting for ack or ack timeout
// RDOUT  | holding read word on rdata until rdata_ready
// FINISH | one-cycle done/error pulse before IDLE
module neuron_core_bus_master
    import neuron_core_bus_master_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_region,
    input  logic        cmd_we,
    input  logic [10:0] cmd_index,
    input  logic [11:0] cmd_len,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic [31:0] rdata,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state;
    logic [1:0]  region_q;
    logic        we_q;
    logic [10:0] index_q;
    logic [11:0] beats_left;
    logic [7:0]  ack_timer;

    logic [1:0]  enc_region;
    logic [10:0] enc_index;
    logic [14:0] enc_offset;
    logic [31:0] beat_adr;

    // Gated by reset so the core never offers to accept while held in reset.
    assign cmd_ready = (state == ST_IDLE) && wb_rst_n;
    assign wbm_sel_o = {4{wbm_cyc_o}};
    assign beat_adr  = {BASE_ADDR[31:15], enc_offset};

    always_comb begin
        enc_region = region_q;
        enc_index  = index_q;
        if (state == ST_IDLE) begin
            enc_region = cmd_region;
            enc_index  = cmd_index;
        end
    end

    neuron_core_addr_encoder u_addr_encoder (
        .region (enc_region),
        .index  (enc_index),
        .offset (enc_offset)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state       <= ST_IDLE;
            region_q    <= '0;
            we_q        <= 1'b0;
            index_q     <= '0;
            beats_left  <= '0;
            ack_timer   <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            wdata_ready <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        region_q   <= cmd_region;
                        we_q       <= cmd_we;
                        index_q    <= cmd_index;
                        beats_left <= cmd_len;
                        busy       <= 1'b1;
                        if (cmd_region == REGION_ILLEGAL || cmd_len == 12'd0) begin
                            error <= 1'b1;
                            state <= ST_FINISH;
                        end else if (cmd_we) begin
                            wdata_ready <= 1'b1;
                            state       <= ST_FETCH;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= 1'b0;
                            wbm_adr_o <= beat_adr;
                            ack_timer <= 8'(ACK_TIMEOUT);
                            state     <= ST_BUS;
                        end
                    end
                end
                ST_FETCH: begin
                    if (wdata_valid) begin
                        wdata_ready <= 1'b0;
                        wbm_dat_o   <= wdata;
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= 1'b1;
                        wbm_adr_o   <= beat_adr;
                        ack_timer   <= 8'(ACK_TIMEOUT);
                        state       <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        index_q    <= next_index(region_q, index_q);
                        beats_left <= beats_left - 12'd1;
                        if (!we_q) begin
                            rdata       <= wbm_dat_i;
                            rdata_valid <= 1'b1;
                            state       <= ST_RDOUT;
                        end else if (beats_left == 12'd1) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            wdata_ready <= 1'b1;
                            state       <= ST_FETCH;
                        end
                    end else if (ack_timer == 8'd1) begin
                        // Unresponsive slave: drop the burst entirely.
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        ack_timer <= ack_timer - 8'd1;
                    end
                end
                ST_RDOUT: begin
                    if (rdata_ready) begin
                        rdata_valid <= 1'b0;
                        if (beats_left == 12'd0) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_adr_o <= beat_adr;
                            ack_timer <= 8'(ACK_TIMEOUT);
                            state     <= ST_BUS;
                        end
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_core_bus_master.sv
// Directed bench for neuron_core_bus_master with a simple Wishbone slave model.
module tb_neuron_core_bus_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_region = '0;
    logic        cmd_we = 1'b0;
    logic [10:0] cmd_index = '0;
    logic [11:0] cmd_len = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [31:0] wdata = '0;
    logic        rdata_valid;
    logic        rdata_ready = 1'b0;
    logic [31:0] rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    logic        busy, done, error;

    int checks = 0;
    int failures = 0;

    // slave model state and logs
    logic        slave_en = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          n_beats = 0;
    logic [31:0] rd_words [8];
    logic [31:0] log_adr [8];
    logic [31:0] log_dat [8];
    logic        log_we [8];

    int          done_cnt = 0, err_cnt = 0, both_cnt = 0, cyc_cnt = 0, n_rd = 0;
    logic [31:0] rd_got [8];

    neuron_core_bus_master #(
        .BASE_ADDR   (32'h3000_0000),
        .ACK_TIMEOUT (4)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_n    (wb_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_region  (cmd_region),
        .cmd_we      (cmd_we),
        .cmd_index   (cmd_index),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) begin
        if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
        end else if (slave_en && wbm_cyc_o && wbm_stb_o) begin
            if (wait_cnt >= ack_delay) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = rd_words[n_beats % 8];
                log_adr[n_beats % 8] = wbm_adr_o;
                log_dat[n_beats % 8] = wbm_dat_o;
                log_we[n_beats % 8]  = wbm_we_o;
                n_beats = n_beats + 1;
                wait_cnt = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    always @(negedge wb_clk_i) begin
        if (done) done_cnt = done_cnt + 1;
        if (error) err_cnt = err_cnt + 1;
        if (done && error) both_cnt = both_cnt + 1;
        if (wbm_cyc_o) cyc_cnt = cyc_cnt + 1;
        if (rdata_valid && rdata_ready) begin
            rd_got[n_rd % 8] = rdata;
            n_rd = n_rd + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] r, input logic w, input logic [10:0] i,
                            input logic [11:0] l);
        int k;
        k = 0;
        @(negedge wb_clk_i);
        while (!cmd_ready && k < 50) begin
            @(negedge wb_clk_i);
            k++;
        end
        if (!cmd_ready) check_val("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid  = 1'b1;
        cmd_region = r;
        cmd_we     = w;
        cmd_index  = i;
        cmd_len    = l;
        @(negedge wb_clk_i);
        cmd_valid  = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        int k;
        k = 0;
        wdata_valid = 1'b1;
        wdata       = d;
        while (!wdata_ready && k < 100) begin
            @(negedge wb_clk_i);
            k++;
        end
        if (!wdata_ready) check_val("wdata_ready_wait", 32'(wdata_ready), 32'd1);
        @(negedge wb_clk_i);
        wdata_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge wb_clk_i);
        while (!cmd_ready && k < 200) begin
            @(negedge wb_clk_i);
            k++;
        end
        if (!cmd_ready) check_val("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic clear_counts();
        done_cnt = 0; err_cnt = 0; both_cnt = 0; cyc_cnt = 0; n_rd = 0; n_beats = 0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rd_words[i] = 32'h0;

        // reset state
        repeat (3) @(negedge wb_clk_i);
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check_val("rst_sel", 32'(wbm_sel_o), 32'd0);
        check_val("rst_adr", wbm_adr_o, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        wb_rst_n = 1'b1;
        #1;
        check_val("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // write synapse 2047, two beats, wraps to 0
        clear_counts();
        send_cmd(2'b00, 1'b1, 11'd2047, 12'd2);
        check_val("w_busy", 32'(busy), 32'd1);
        push_word(32'hA5A5_0001);
        push_word(32'h5A5A_0002);
        wait_idle();
        check_val("w_beats", 32'(n_beats), 32'd2);
        check_val("w_adr0", log_adr[0], 32'h3000_1FFC);
        check_val("w_adr1", log_adr[1], 32'h3000_0000);
        check_val("w_dat0", log_dat[0], 32'hA5A5_0001);
        check_val("w_dat1", log_dat[1], 32'h5A5A_0002);
        check_val("w_we0", 32'(log_we[0]), 32'd1);
        check_val("w_done", 32'(done_cnt), 32'd1);
        check_val("w_err", 32'(err_cnt), 32'd0);

        // read param 5 with rdata back-pressure
        clear_counts();
        rd_words[0] = 32'hDEAD_BEEF;
        rdata_ready = 1'b0;
        send_cmd(2'b01, 1'b0, 11'd5, 12'd1);
        for (int k = 0; k < 20 && !rdata_valid; k++) @(negedge wb_clk_i);
        check_val("r1_valid", 32'(rdata_valid), 32'd1);
        check_val("r1_adr", log_adr[0], 32'h3000_2050);
        check_val("r1_we", 32'(log_we[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge wb_clk_i);
            check_val("r1_hold_data", rdata, 32'hDEAD_BEEF);
            check_val("r1_hold_valid", 32'(rdata_valid), 32'd1);
        end
        rdata_ready = 1'b1;
        @(negedge wb_clk_i);
        rdata_ready = 1'b0;
        check_val("r1_valid_drop", 32'(rdata_valid), 32'd0);
        wait_idle();
        check_val("r1_done", 32'(done_cnt), 32'd1);

        // read spike 7, two beats wrapping to 0
        clear_counts();
        rd_words[0] = 32'h1111_0000;
        rd_words[1] = 32'h2222_0001;
        rdata_ready = 1'b1;
        send_cmd(2'b10, 1'b0, 11'd7, 12'd2);
        wait_idle();
        check_val("r2_beats", 32'(n_beats), 32'd2);
        check_val("r2_adr0", log_adr[0], 32'h3000_401C);
        check_val("r2_adr1", log_adr[1], 32'h3000_4000);
        check_val("r2_n_rd", 32'(n_rd), 32'd2);
        check_val("r2_rd0", rd_got[0], 32'h1111_0000);
        check_val("r2_rd1", rd_got[1], 32'h2222_0001);
        check_val("r2_done", 32'(done_cnt), 32'd1);

        // illegal commands
        clear_counts();
        send_cmd(2'b11, 1'b1, 11'd0, 12'd1);
        wait_idle();
        send_cmd(2'b00, 1'b0, 11'd0, 12'd0);
        wait_idle();
        check_val("ill_err", 32'(err_cnt), 32'd2);
        check_val("ill_done", 32'(done_cnt), 32'd0);
        check_val("ill_cyc", 32'(cyc_cnt), 32'd0);

        // ack timeout
        clear_counts();
        slave_en = 1'b0;
        send_cmd(2'b00, 1'b0, 11'd3, 12'd1);
        for (int k = 0; k < 30 && !error; k++) @(negedge wb_clk_i);
        check_val("to_error", 32'(error), 32'd1);
        check_val("to_cyc_low", 32'(wbm_cyc_o), 32'd0);
        check_val("to_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("to_cyc_cycles", 32'(cyc_cnt), 32'd4);
        check_val("to_done", 32'(done_cnt), 32'd0);
        slave_en = 1'b1;
        @(negedge wb_clk_i);

        // reset in the middle of beat 3 of an 8-beat write
        clear_counts();
        ack_delay = 2;
        send_cmd(2'b00, 1'b1, 11'd10, 12'd8);
        push_word(32'h0000_0100);
        push_word(32'h0000_0101);
        push_word(32'h0000_0102);
        check_val("mid_cyc", 32'(wbm_cyc_o), 32'd1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        check_val("mid_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check_val("mid_rst_stb", 32'(wbm_stb_o), 32'd0);
        check_val("mid_rst_adr", wbm_adr_o, 32'd0);
        check_val("mid_rst_dat", wbm_dat_o, 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_val("mid_beats", 32'(n_beats), 32'd2);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        check_val("mid_no_done", 32'(done_cnt), 32'd0);
        check_val("mid_no_err", 32'(err_cnt), 32'd0);

        clear_counts();
        ack_delay = 0;
        rd_words[0] = 32'hCAFE_F00D;
        send_cmd(2'b10, 1'b0, 11'd3, 12'd1);
        wait_idle();
        check_val("after_adr", log_adr[0], 32'h3000_400C);
        check_val("after_rdata", rdata, 32'hCAFE_F00D);
        check_val("after_done", 32'(done_cnt), 32'd1);
        check_val("never_both", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
